// File: rtl/ccu_pkg.sv
// Shared definitions for the CCU snoop dispatcher: CRRESP bit positions and the
// dispatch state encoding.
package ccu_pkg;

   localparam int CR_DT  = 0;
   localparam int CR_ERR = 1;
   localparam int CR_PD  = 2;
   localparam int CR_IS  = 3;
   localparam int CR_WU  = 4;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      ISSUE   = 3'd1,
      COLLECT = 3'd2,
      CR_OUT  = 3'd3,
      DATA    = 3'd4
   } dispatch_state_e;

endpackage

// File: rtl/ace_ccu_snoop_rr_arb.sv
// N-way round-robin arbiter: combinational grant searched from the pointer,
// pointer moves past the winner only when the grant is taken.
module ace_ccu_snoop_rr_arb #(
   parameter int unsigned N    = 2,
   parameter int unsigned IdxW = (N > 1) ? $clog2(N) : 1
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [N-1:0]    req,
   input  logic            hs,
   output logic [N-1:0]    gnt,
   output logic [IdxW-1:0] idx,
   output logic            any
);

   logic [IdxW-1:0] ptr_q;
   logic [IdxW:0]   cand;

   always_comb begin
      gnt  = '0;
      idx  = '0;
      any  = 1'b0;
      cand = '0;
      for (int i = 0; i < int'(N); i++) begin
         cand = {1'b0, ptr_q} + (IdxW+1)'(i);
         if (cand >= (IdxW+1)'(N)) cand = cand - (IdxW+1)'(N);
         if (!any && req[cand[IdxW-1:0]]) begin
            any                  = 1'b1;
            gnt[cand[IdxW-1:0]] = 1'b1;
            idx                  = cand[IdxW-1:0];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_q <= '0;
      end else if (hs && any) begin
         ptr_q <= (idx == IdxW'(N-1)) ? '0 : idx + 1'b1;
      end
   end

endmodule

// File: rtl/ace_ccu_snoop_dispatch.sv
// Snoop dispatcher: round-robin over NumPaths requesters, forks AC to masked caches,
// merges CR, forwards one cache's line and drains the rest. Optional perf counters
// are enabled by ACE_CCU_SNOOP_PERF_EN.
module ace_ccu_snoop_dispatch
   import ccu_pkg::*;
#(
   parameter int unsigned NumPaths    = 2,
   parameter int unsigned NumCaches   = 4,
   parameter int unsigned AddrWidth   = 64,
   parameter int unsigned LineWidth   = 512,
   parameter int unsigned CdDataWidth = 64
) (
   input  logic                             clk_i,
   input  logic                             rst_ni,
`ifdef ACE_CCU_SNOOP_PERF_EN
   output logic [31:0]                      perf_snoops_o,
   output logic [31:0]                      perf_data_o,
   output logic [31:0]                      perf_dirty_o,
`endif
   output dispatch_state_e                  dbg_state,
   input  logic [NumPaths-1:0]              path_ac_valid_i,
   output logic [NumPaths-1:0]              path_ac_ready_o,
   input  logic [NumPaths*AddrWidth-1:0]    path_ac_addr_i,
   input  logic [NumPaths*4-1:0]            path_ac_snoop_i,
   input  logic [NumPaths*NumCaches-1:0]    path_ac_mask_i,
   output logic [NumPaths-1:0]              path_cr_valid_o,
   input  logic [NumPaths-1:0]              path_cr_ready_i,
   output logic [4:0]                       path_cr_resp_o,
   output logic [NumPaths-1:0]              path_cd_valid_o,
   input  logic [NumPaths-1:0]              path_cd_ready_i,
   output logic [CdDataWidth-1:0]           path_cd_data_o,
   output logic                             path_cd_last_o,
   output logic [NumCaches-1:0]             ac_valid_o,
   input  logic [NumCaches-1:0]             ac_ready_i,
   output logic [AddrWidth-1:0]             ac_addr_o,
   output logic [3:0]                       ac_snoop_o,
   input  logic [NumCaches-1:0]             cr_valid_i,
   output logic [NumCaches-1:0]             cr_ready_o,
   input  logic [NumCaches*5-1:0]           cr_resp_i,
   input  logic [NumCaches-1:0]             cd_valid_i,
   output logic [NumCaches-1:0]             cd_ready_o,
   input  logic [NumCaches*CdDataWidth-1:0] cd_data_i,
   input  logic [NumCaches-1:0]             cd_last_i
);

   localparam int unsigned CdBeats = LineWidth / CdDataWidth;
   localparam int unsigned IdxW    = (NumPaths > 1) ? $clog2(NumPaths) : 1;
   localparam int unsigned CIdxW   = (NumCaches > 1) ? $clog2(NumCaches) : 1;
   localparam int unsigned CntW    = (CdBeats > 1) ? $clog2(CdBeats) : 1;

   dispatch_state_e       state_q, state_d;
   logic [IdxW-1:0]       owner_q;
   logic [AddrWidth-1:0]  addr_q;
   logic [3:0]            snoop_q;
   logic [NumCaches-1:0]  ac_pend_q, ac_pend_d;
   logic [NumCaches-1:0]  cr_pend_q, cr_pend_d;
   logic [NumCaches-1:0]  dt_q, dt_d;
   logic [NumCaches-1:0]  src_q, src_d;
   logic [4:0]            resp_q, resp_d;
   logic [CntW-1:0]       cnt_q, cnt_d;

   logic [NumPaths-1:0]   arb_req;
   logic [NumPaths-1:0]   gnt_oh;
   logic [IdxW-1:0]       gnt_idx;
   logic                  gnt_any;
   logic [NumCaches-1:0]  gnt_mask;
   logic [NumCaches-1:0]  cr_hs;
   logic [NumCaches-1:0]  cr_dt;
   logic [4:0]            cr_or;
   logic [NumCaches-1:0]  drain;
   logic                  sel_live;
   logic [CIdxW-1:0]      sel_idx;

   // Requests are only offered to the arbiter while idle, so a grant is a handshake.
   assign arb_req = path_ac_valid_i & {NumPaths{state_q == IDLE}};

   ace_ccu_snoop_rr_arb #(
      .N    (NumPaths),
      .IdxW (IdxW)
   ) u_arb (
      .clk   (clk_i),
      .rst_n (rst_ni),
      .req   (arb_req),
      .hs    (gnt_any),
      .gnt   (gnt_oh),
      .idx   (gnt_idx),
      .any   (gnt_any)
   );

   assign path_ac_ready_o = gnt_oh;
   assign gnt_mask        = path_ac_mask_i[gnt_idx*NumCaches +: NumCaches];
   assign ac_addr_o       = addr_q;
   assign ac_snoop_o      = snoop_q;
   assign path_cr_resp_o  = resp_q;
   assign path_cd_data_o  = cd_data_i[sel_idx*CdDataWidth +: CdDataWidth];
   assign dbg_state       = state_q;

   always_comb begin
      sel_idx = '0;
      for (int c = 0; c < int'(NumCaches); c++) begin
         if (src_q[c]) sel_idx = CIdxW'(c);
      end
   end

   always_comb begin
      state_d         = state_q;
      ac_pend_d       = ac_pend_q;
      cr_pend_d       = cr_pend_q;
      dt_d            = dt_q;
      src_d           = src_q;
      resp_d          = resp_q;
      cnt_d           = cnt_q;
      ac_valid_o      = '0;
      cr_ready_o      = '0;
      cd_ready_o      = '0;
      path_cr_valid_o = '0;
      path_cd_valid_o = '0;
      path_cd_last_o  = 1'b0;
      sel_live        = 1'b0;
      drain           = '0;
      cr_hs           = '0;
      cr_dt           = '0;
      cr_or           = '0;

      case (state_q)
         IDLE: begin
            if (gnt_any) begin
               ac_pend_d = gnt_mask;
               cr_pend_d = gnt_mask;
               resp_d    = '0;
               dt_d      = '0;
               src_d     = '0;
               cnt_d     = '0;
               state_d   = (gnt_mask == '0) ? CR_OUT : ISSUE;
            end
         end
         ISSUE: begin
            ac_valid_o = ac_pend_q;
            cr_ready_o = cr_pend_q & ~ac_pend_q;
            ac_pend_d  = ac_pend_q & ~ac_ready_i;
            if (ac_pend_d == '0) state_d = COLLECT;
         end
         COLLECT: begin
            cr_ready_o = cr_pend_q;
         end
         CR_OUT: begin
            path_cr_valid_o[owner_q] = 1'b1;
            if (path_cr_ready_i[owner_q]) begin
               if (dt_q != '0) begin
                  state_d = DATA;
                  src_d   = dt_q & (~dt_q + 1'b1);
                  cnt_d   = '0;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         DATA: begin
            // The forwarding source is frozen at entry so draining caches never take over.
            sel_live   = |(dt_q & src_q);
            drain      = dt_q & ~src_q;
            cd_ready_o = drain;
            dt_d       = dt_q & ~(drain & cd_valid_i & cd_last_i);
            if (sel_live) begin
               path_cd_valid_o[owner_q] = cd_valid_i[sel_idx];
               cd_ready_o[sel_idx]      = path_cd_ready_i[owner_q];
               path_cd_last_o           = (cnt_q == CntW'(CdBeats-1));
               if (cd_valid_i[sel_idx] && path_cd_ready_i[owner_q]) begin
                  if (path_cd_last_o) begin
                     cnt_d = '0;
                     dt_d  = dt_d & ~src_q;
                  end else begin
                     cnt_d = cnt_q + 1'b1;
                  end
               end
            end
            if (dt_d == '0) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      // CR merge is shared by ISSUE (early responders) and COLLECT.
      cr_hs = cr_valid_i & cr_ready_o;
      for (int c = 0; c < int'(NumCaches); c++) begin
         if (cr_hs[c]) cr_or = cr_or | cr_resp_i[c*5 +: 5];
         cr_dt[c] = cr_hs[c] & cr_resp_i[c*5 + CR_DT];
      end
      resp_d    = resp_d | cr_or;
      dt_d      = dt_d | cr_dt;
      cr_pend_d = cr_pend_d & ~cr_hs;
      if (state_q == COLLECT && cr_pend_d == '0) state_d = CR_OUT;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q   <= IDLE;
         owner_q   <= '0;
         addr_q    <= '0;
         snoop_q   <= '0;
         ac_pend_q <= '0;
         cr_pend_q <= '0;
         dt_q      <= '0;
         src_q     <= '0;
         resp_q    <= '0;
         cnt_q     <= '0;
      end else begin
         state_q   <= state_d;
         ac_pend_q <= ac_pend_d;
         cr_pend_q <= cr_pend_d;
         dt_q      <= dt_d;
         src_q     <= src_d;
         resp_q    <= resp_d;
         cnt_q     <= cnt_d;
         if (state_q == IDLE && gnt_any) begin
            owner_q <= gnt_idx;
            addr_q  <= path_ac_addr_i[gnt_idx*AddrWidth +: AddrWidth];
            snoop_q <= path_ac_snoop_i[gnt_idx*4 +: 4];
         end
      end
   end

`ifdef ACE_CCU_SNOOP_PERF_EN
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         perf_snoops_o <= '0;
         perf_data_o   <= '0;
         perf_dirty_o  <= '0;
      end else begin
         if (state_q == IDLE && gnt_any && perf_snoops_o != '1)
            perf_snoops_o <= perf_snoops_o + 1'b1;
         if (state_q == CR_OUT && state_d == DATA && perf_data_o != '1)
            perf_data_o <= perf_data_o + 1'b1;
         if (state_q == CR_OUT && path_cr_ready_i[owner_q] && resp_q[CR_PD] &&
             perf_dirty_o != '1)
            perf_dirty_o <= perf_dirty_o + 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_ace_ccu_snoop_dispatch.sv
// Directed bench for ace_ccu_snoop_dispatch: arbitration, AC fork, CR merge,
// data forward/drain, back-pressure and reset abort.
module tb_ace_ccu_snoop_dispatch;
   import ccu_pkg::*;

   localparam int NP = 2;
   localparam int NC = 4;
   localparam int AW = 64;
   localparam int DW = 64;

   logic              clk;
   logic              rst_n;
   dispatch_state_e   dbg_state;
   logic [NP-1:0]     path_ac_valid, path_ac_ready;
   logic [NP*AW-1:0]  path_ac_addr;
   logic [NP*4-1:0]   path_ac_snoop;
   logic [NP*NC-1:0]  path_ac_mask;
   logic [NP-1:0]     path_cr_valid, path_cr_ready;
   logic [4:0]        path_cr_resp;
   logic [NP-1:0]     path_cd_valid, path_cd_ready;
   logic [DW-1:0]     path_cd_data;
   logic              path_cd_last;
   logic [NC-1:0]     ac_valid, ac_ready;
   logic [AW-1:0]     ac_addr;
   logic [3:0]        ac_snoop;
   logic [NC-1:0]     cr_valid, cr_ready;
   logic [NC*5-1:0]   cr_resp;
   logic [NC-1:0]     cd_valid, cd_ready, cd_last;
   logic [NC*DW-1:0]  cd_data;

   int errors = 0;
   int checks = 0;
   logic [DW-1:0] exp_q[$];
   logic [DW-1:0] exp_beat;

   ace_ccu_snoop_dispatch dut (
      .clk_i           (clk),
      .rst_ni          (rst_n),
      .dbg_state       (dbg_state),
      .path_ac_valid_i (path_ac_valid),
      .path_ac_ready_o (path_ac_ready),
      .path_ac_addr_i  (path_ac_addr),
      .path_ac_snoop_i (path_ac_snoop),
      .path_ac_mask_i  (path_ac_mask),
      .path_cr_valid_o (path_cr_valid),
      .path_cr_ready_i (path_cr_ready),
      .path_cr_resp_o  (path_cr_resp),
      .path_cd_valid_o (path_cd_valid),
      .path_cd_ready_i (path_cd_ready),
      .path_cd_data_o  (path_cd_data),
      .path_cd_last_o  (path_cd_last),
      .ac_valid_o      (ac_valid),
      .ac_ready_i      (ac_ready),
      .ac_addr_o       (ac_addr),
      .ac_snoop_o      (ac_snoop),
      .cr_valid_i      (cr_valid),
      .cr_ready_o      (cr_ready),
      .cr_resp_i       (cr_resp),
      .cd_valid_i      (cd_valid),
      .cd_ready_o      (cd_ready),
      .cd_data_i       (cd_data),
      .cd_last_i       (cd_last)
   );

   // Clock and reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Driver tasks
   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic clear_inputs();
      path_ac_valid = '0; path_ac_addr = '0; path_ac_snoop = '0; path_ac_mask = '0;
      path_cr_ready = '0; path_cd_ready = '0;
      ac_ready = '0; cr_valid = '0; cr_resp = '0;
      cd_valid = '0; cd_data = '0; cd_last = '0;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      clear_inputs();
      rst_n = 1'b0;
      #2;
      chk("rst_state", 64'(dbg_state), 64'(IDLE));
      chk("rst_ac_ready", 64'(path_ac_ready), 64'h0);
      chk("rst_ac_valid", 64'(ac_valid), 64'h0);
      chk("rst_cr_valid", 64'(path_cr_valid), 64'h0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // Round robin: both paths valid, mask 0
      path_ac_valid = 2'b11;
      path_ac_addr  = {64'h2000, 64'h1000};
      #1 chk("rr_first", 64'(path_ac_ready), 64'h1);
      step();
      path_ac_valid = 2'b10;
      #1 chk("rr_cr0_valid", 64'(path_cr_valid), 64'h1);
      chk("rr_cr0_resp", 64'(path_cr_resp), 64'h0);
      chk("rr_no_ac", 64'(ac_valid), 64'h0);
      chk("rr_busy_ready", 64'(path_ac_ready), 64'h0);
      path_cr_ready = 2'b01;
      step();
      path_cr_ready = 2'b00;
      #1 chk("rr_second", 64'(path_ac_ready), 64'h2);
      step();
      path_ac_valid = 2'b00;
      #1 chk("rr_cr1_valid", 64'(path_cr_valid), 64'h2);
      chk("rr_addr1", ac_addr, 64'h2000);
      path_cr_ready = 2'b10;
      step();
      path_cr_ready = 2'b00;

      // Mask 0, both valid again: pointer wrapped to 0
      path_ac_valid = 2'b11;
      path_ac_addr  = {64'h2000, 64'h3000};
      #1 chk("m0_grant", 64'(path_ac_ready), 64'h1);
      step();
      path_ac_valid = 2'b00;
      #1 chk("m0_cr_valid", 64'(path_cr_valid), 64'h1);
      chk("m0_resp", 64'(path_cr_resp), 64'h0);
      chk("m0_state", 64'(dbg_state), 64'(CR_OUT));
      path_cr_ready = 2'b01;
      step();
      path_cr_ready = 2'b00;

      // Fork with mask 0101, cache2 late; early CR from cache0
      path_ac_valid = 2'b01;
      path_ac_addr  = {64'h0, 64'h40};
      path_ac_snoop = 8'h0B;
      path_ac_mask  = {4'b1010, 4'b0101};
      #1 chk("fork_grant", 64'(path_ac_ready), 64'h1);
      step();
      path_ac_valid = 2'b00;
      ac_ready = 4'b0001;
      #1 chk("fork_ac_valid", 64'(ac_valid), 64'h5);
      chk("fork_addr", ac_addr, 64'h40);
      chk("fork_snoop", 64'(ac_snoop), 64'hB);
      step();
      ac_ready = 4'b0000;
      cr_valid = 4'b0001;
      cr_resp  = '0;
      cr_resp[0 +: 5] = 5'b01000;
      #1 chk("fork_hold1", 64'(ac_valid), 64'h4);
      chk("fork_early_cr", 64'(cr_ready), 64'h1);
      step();
      cr_valid = 4'b0000;
      for (int i = 0; i < 2; i++) begin
         #1 chk("fork_hold", 64'(ac_valid), 64'h4);
         step();
      end
      ac_ready = 4'b0100;
      #1 chk("fork_ac2", 64'(ac_valid), 64'h4);
      chk("fork_cr2_blocked", 64'(cr_ready), 64'h0);
      step();
      ac_ready = 4'b0000;
      #1 chk("collect_state", 64'(dbg_state), 64'(COLLECT));
      chk("collect_ready", 64'(cr_ready), 64'h4);
      cr_valid = 4'b0100;
      cr_resp  = '0;
      cr_resp[10 +: 5] = 5'b00100;
      step();
      cr_valid = 4'b0000;
      path_ac_valid = 2'b10;
      path_ac_addr  = {64'h80, 64'h40};
      path_ac_snoop = 8'h1B;
      // Back-pressure: response held for 5 cycles, no new grant
      for (int i = 0; i < 5; i++) begin
         #1 chk("bp_cr_valid", 64'(path_cr_valid), 64'h1);
         chk("bp_resp", 64'(path_cr_resp), 64'h0C);
         chk("bp_no_grant", 64'(path_ac_ready), 64'h0);
         step();
      end
      path_cr_ready = 2'b01;
      step();
      path_cr_ready = 2'b00;
      #1 chk("p1_grant", 64'(path_ac_ready), 64'h2);
      step();

      // Path1, mask 1010: merge and data forward from cache1, drain cache3
      path_ac_valid = 2'b00;
      ac_ready = 4'b1010;
      #1 chk("p1_ac_valid", 64'(ac_valid), 64'hA);
      chk("p1_snoop", 64'(ac_snoop), 64'h1);
      step();
      ac_ready = 4'b0000;
      cr_valid = 4'b1010;
      cr_resp  = '0;
      cr_resp[5 +: 5]  = 5'b00001;
      cr_resp[15 +: 5] = 5'b01101;
      #1 chk("p1_cr_ready", 64'(cr_ready), 64'hA);
      step();
      cr_valid = 4'b0000;
      #1 chk("p1_cr_valid", 64'(path_cr_valid), 64'h2);
      chk("p1_merged", 64'(path_cr_resp), 64'h0D);
      path_cr_ready = 2'b10;
      step();
      path_cr_ready = 2'b00;
      for (int b = 0; b < 8; b++) exp_q.push_back(64'hC1_0000 + 64'(b));
      path_cd_ready = 2'b10;
      for (int b = 0; b < 8; b++) begin
         cd_valid = {(b <= 1), 1'b0, 1'b1, 1'b0};
         cd_last  = {(b == 1), 3'b000};
         cd_data  = '0;
         cd_data[1*DW +: DW] = 64'hC1_0000 + 64'(b);
         cd_data[3*DW +: DW] = 64'hDEAD_0000 + 64'(b);
         exp_beat = exp_q.pop_front();
         #1 chk("cd_valid", 64'(path_cd_valid), 64'h2);
         chk("cd_data", path_cd_data, exp_beat);
         chk("cd_last", 64'(path_cd_last), 64'(b == 7));
         chk("cd_ready", 64'(cd_ready), (b <= 1) ? 64'hA : 64'h2);
         step();
      end
      cd_valid = '0; cd_last = '0; path_cd_ready = '0;
      #1 chk("data_done_state", 64'(dbg_state), 64'(IDLE));
      chk("data_done_valid", 64'(path_cd_valid), 64'h0);
      chk("data_queue_empty", 64'(exp_q.size()), 64'h0);

      // Reset during DATA
      path_ac_valid = 2'b01;
      path_ac_addr  = {64'h0, 64'hC0};
      path_ac_mask  = {4'b0000, 4'b0001};
      #1 chk("rd_grant", 64'(path_ac_ready), 64'h1);
      step();
      path_ac_valid = 2'b00;
      ac_ready = 4'b0001;
      step();
      ac_ready = 4'b0000;
      cr_valid = 4'b0001;
      cr_resp  = '0;
      cr_resp[0 +: 5] = 5'b00001;
      step();
      cr_valid = 4'b0000;
      path_cr_ready = 2'b01;
      step();
      path_cr_ready = 2'b00;
      cd_valid = 4'b0001;
      path_cd_ready = 2'b01;
      cd_data[0 +: DW] = 64'h55;
      #1 chk("rd_in_data", 64'(path_cd_valid), 64'h1);
      step();
      rst_n = 1'b0;
      #1 chk("rd_state", 64'(dbg_state), 64'(IDLE));
      chk("rd_cd_valid", 64'(path_cd_valid), 64'h0);
      chk("rd_cd_ready", 64'(cd_ready), 64'h0);
      chk("rd_cd_last", 64'(path_cd_last), 64'h0);
      chk("rd_ac_ready", 64'(path_ac_ready), 64'h0);
      clear_inputs();
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      path_ac_valid = 2'b11;
      #1 chk("post_rst_grant", 64'(path_ac_ready), 64'h1);
      step();
      path_ac_valid = 2'b00;
      #1 chk("post_rst_cr", 64'(path_cr_valid), 64'h1);
      path_cr_ready = 2'b01;
      step();
      path_cr_ready = 2'b00;
      #1 chk("post_rst_idle", 64'(dbg_state), 64'(IDLE));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
